// File: rtl/superh16_branch_recovery_ctrl.sv
// Misprediction recovery sequencer: picks the oldest mispredicted branch by ROB age,
// then drives flush, rename restore and fetch redirect in order, with preemption by older branches.
module superh16_branch_recovery_ctrl #(
  parameter int unsigned NUM_BR_UNITS = 2,
  parameter int unsigned ROB_IDX_BITS = 9,
  parameter int unsigned VADDR_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_BR_UNITS-1:0]               br_resolved,
  input  logic [NUM_BR_UNITS-1:0]               br_mispredicted,
  input  logic [NUM_BR_UNITS*ROB_IDX_BITS-1:0]  br_rob_idx,
  input  logic [NUM_BR_UNITS*VADDR_WIDTH-1:0]   br_target,
  input  logic [ROB_IDX_BITS-1:0]               rob_head_idx,
  output logic                                  flush_valid,
  output logic [ROB_IDX_BITS-1:0]               flush_rob_idx,
  output logic                                  recover_req,
  input  logic                                  recover_done,
  output logic                                  redirect_valid,
  output logic [VADDR_WIDTH-1:0]                redirect_pc,
  input  logic                                  fetch_ready,
  output logic                                  stall_issue,
  output logic [CNT_WIDTH-1:0]                  mispredict_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_RECOVER  = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ROB_IDX_BITS-1:0] cur_idx_q, cur_idx_d;
  logic [VADDR_WIDTH-1:0]  cur_pc_q, cur_pc_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    flush_valid_q;
  logic                    recover_req_q;
  logic                    redirect_valid_q;
  logic [VADDR_WIDTH-1:0]  redirect_pc_q;
  logic                    stall_issue_q;

  logic                    win_valid;
  logic [ROB_IDX_BITS-1:0] win_idx;
  logic [ROB_IDX_BITS-1:0] win_age;
  logic [VADDR_WIDTH-1:0]  win_pc;
  logic [ROB_IDX_BITS-1:0] cand_idx;
  logic [ROB_IDX_BITS-1:0] cand_age;
  logic [ROB_IDX_BITS-1:0] cur_age;
  logic                    preempt;
  logic                    accept;

  // Oldest-candidate select; modular age handles ROB wrap, strict < gives ties to the lower unit.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_age   = '0;
    win_pc    = '0;
    cand_idx  = '0;
    cand_age  = '0;
    for (int unsigned i = 0; i < NUM_BR_UNITS; i++) begin
      cand_idx = br_rob_idx[i*ROB_IDX_BITS +: ROB_IDX_BITS];
      cand_age = cand_idx - rob_head_idx;
      if (br_resolved[i] && br_mispredicted[i] && (!win_valid || (cand_age < win_age))) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
        win_age   = cand_age;
        win_pc    = br_target[i*VADDR_WIDTH +: VADDR_WIDTH];
      end
    end
  end

  assign cur_age = cur_idx_q - rob_head_idx;
  assign preempt = (state_q != S_IDLE) && win_valid && (win_age < cur_age);

  // Next-state; a preemption overrides any handshake completing in the same cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          accept  = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:    state_d = S_RECOVER;
      S_RECOVER:  if (recover_done) state_d = S_REDIRECT;
      S_REDIRECT: if (fetch_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (preempt) begin
      accept  = 1'b1;
      state_d = S_FLUSH;
    end
  end

  // Latched recovery target and saturating counter.
  always_comb begin
    cur_idx_d = cur_idx_q;
    cur_pc_d  = cur_pc_q;
    cnt_d     = cnt_q;
    if (accept) begin
      cur_idx_d = win_idx;
      cur_pc_d  = win_pc;
      if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs are registered decodes of the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cur_idx_q        <= '0;
      cur_pc_q         <= '0;
      cnt_q            <= '0;
      flush_valid_q    <= 1'b0;
      recover_req_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_issue_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_idx_q        <= cur_idx_d;
      cur_pc_q         <= cur_pc_d;
      cnt_q            <= cnt_d;
      flush_valid_q    <= (state_d == S_FLUSH);
      recover_req_q    <= (state_d == S_RECOVER);
      redirect_valid_q <= (state_d == S_REDIRECT);
      stall_issue_q    <= (state_d != S_IDLE);
      if (state_d == S_REDIRECT) begin
        redirect_pc_q <= cur_pc_d;
      end
    end
  end

  assign flush_valid      = flush_valid_q;
  assign flush_rob_idx    = cur_idx_q;
  assign recover_req      = recover_req_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign stall_issue      = stall_issue_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_superh16_branch_recovery_ctrl.sv
// Directed bench for superh16_branch_recovery_ctrl: vector table plus hand sequences
// for backpressure and mid-recovery reset.
module tb_superh16_branch_recovery_ctrl;

  logic         clk;
  logic         rst_n;
  logic [1:0]   br_resolved;
  logic [1:0]   br_mispredicted;
  logic [17:0]  br_rob_idx;
  logic [127:0] br_target;
  logic [8:0]   rob_head_idx;
  logic         flush_valid;
  logic [8:0]   flush_rob_idx;
  logic         recover_req;
  logic         recover_done;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         fetch_ready;
  logic         stall_issue;
  logic [31:0]  mispredict_count;

  int checks;
  int errors;

  superh16_branch_recovery_ctrl #(
    .NUM_BR_UNITS(2), .ROB_IDX_BITS(9), .VADDR_WIDTH(64), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .br_resolved(br_resolved), .br_mispredicted(br_mispredicted),
    .br_rob_idx(br_rob_idx), .br_target(br_target), .rob_head_idx(rob_head_idx),
    .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
    .recover_req(recover_req), .recover_done(recover_done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .stall_issue(stall_issue),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  res;
    logic [1:0]  mis;
    logic [8:0]  idx0;
    logic [63:0] tgt0;
    logic [8:0]  idx1;
    logic [63:0] tgt1;
    logic [8:0]  head;
    logic        rd;
    logic        fr;
    logic        e_flush;
    logic [8:0]  e_idx;
    logic        e_rec;
    logic        e_redir;
    logic [63:0] e_pc;
    logic        e_stall;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [1:0] res, logic [1:0] mis,
                              logic [8:0] idx0, logic [63:0] tgt0,
                              logic [8:0] idx1, logic [63:0] tgt1, logic [8:0] head,
                              logic rd, logic fr, logic ef, logic [8:0] eidx, logic erec,
                              logic eredir, logic [63:0] epc, logic estall, logic [31:0] ecnt);
    vec_t v;
    v.name = n; v.res = res; v.mis = mis; v.idx0 = idx0; v.tgt0 = tgt0;
    v.idx1 = idx1; v.tgt1 = tgt1; v.head = head; v.rd = rd; v.fr = fr;
    v.e_flush = ef; v.e_idx = eidx; v.e_rec = erec; v.e_redir = eredir;
    v.e_pc = epc; v.e_stall = estall; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    br_resolved     = v.res;
    br_mispredicted = v.mis;
    br_rob_idx      = {v.idx1, v.idx0};
    br_target       = {v.tgt1, v.tgt0};
    rob_head_idx    = v.head;
    recover_done    = v.rd;
    fetch_ready     = v.fr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(logic [8:0] head, logic rd, logic fr);
    @(negedge clk);
    br_resolved = '0; br_mispredicted = '0; br_rob_idx = '0; br_target = '0;
    rob_head_idx = head; recover_done = rd; fetch_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic win0(logic [8:0] idx, logic [63:0] tgt, logic [8:0] head, logic rd, logic fr);
    @(negedge clk);
    br_resolved = 2'b01; br_mispredicted = 2'b01;
    br_rob_idx = {9'd0, idx}; br_target = {64'd0, tgt};
    rob_head_idx = head; recover_done = rd; fetch_ready = fr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    br_resolved = '0; br_mispredicted = '0; br_rob_idx = '0; br_target = '0;
    rob_head_idx = '0; recover_done = 1'b0; fetch_ready = 1'b0;

    //            name                res    mis    idx0 tgt0     idx1 tgt1     head rd fr | fl idx  rec rdr pc       st cnt
    vecs.push_back(mk("single_flush",  2'b01, 2'b01, 5,   'h1000,  0,   0,       0,   1, 1,  1, 5,   0,  0,  0,       1, 1));
    vecs.push_back(mk("single_recov",  2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 5,   1,  0,  0,       1, 1));
    vecs.push_back(mk("single_redir",  2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 5,   0,  1,  'h1000,  1, 1));
    vecs.push_back(mk("single_idle",   2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 0,   0,  0,  0,       0, 1));
    vecs.push_back(mk("wrap_flush",    2'b11, 2'b11, 10,  'hA0,    505, 'hB0,    500, 0, 0,  1, 505, 0,  0,  0,       1, 2));
    vecs.push_back(mk("wrap_recov",    2'b00, 2'b00, 0,   0,       0,   0,       500, 0, 0,  0, 505, 1,  0,  0,       1, 2));
    vecs.push_back(mk("correct_pred",  2'b01, 2'b00, 501, 'hEEE,   0,   0,       500, 0, 0,  0, 505, 1,  0,  0,       1, 2));
    vecs.push_back(mk("wrap_redir",    2'b00, 2'b00, 0,   0,       0,   0,       500, 1, 0,  0, 505, 0,  1,  'hB0,    1, 2));
    vecs.push_back(mk("wrap_idle",     2'b00, 2'b00, 0,   0,       0,   0,       500, 0, 1,  0, 0,   0,  0,  0,       0, 2));
    vecs.push_back(mk("pre_flush40",   2'b01, 2'b01, 40,  'h4000,  0,   0,       0,   0, 0,  1, 40,  0,  0,  0,       1, 3));
    vecs.push_back(mk("pre_recov40",   2'b00, 2'b00, 0,   0,       0,   0,       0,   0, 0,  0, 40,  1,  0,  0,       1, 3));
    vecs.push_back(mk("preempt_recov", 2'b10, 2'b10, 0,   0,       20,  'h2000,  0,   1, 0,  1, 20,  0,  0,  0,       1, 4));
    vecs.push_back(mk("pre_recov20",   2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 0,  0, 20,  1,  0,  0,       1, 4));
    vecs.push_back(mk("pre_redir20",   2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 0,  0, 20,  0,  1,  'h2000,  1, 4));
    vecs.push_back(mk("younger_drop",  2'b01, 2'b01, 30,  'h3000,  0,   0,       0,   0, 0,  0, 20,  0,  1,  'h2000,  1, 4));
    vecs.push_back(mk("same_age_drop", 2'b01, 2'b01, 20,  'h5555,  0,   0,       0,   0, 0,  0, 20,  0,  1,  'h2000,  1, 4));
    vecs.push_back(mk("preempt_redir", 2'b10, 2'b10, 0,   0,       10,  'h1010,  0,   0, 1,  1, 10,  0,  0,  0,       1, 5));
    vecs.push_back(mk("pre_recov10",   2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 10,  1,  0,  0,       1, 5));
    vecs.push_back(mk("pre_redir10",   2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 10,  0,  1,  'h1010,  1, 5));
    vecs.push_back(mk("pre_idle",      2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 1,  0, 0,   0,  0,  0,       0, 5));
    vecs.push_back(mk("tie_flush",     2'b11, 2'b11, 7,   'h70,    7,   'h71,    0,   0, 0,  1, 7,   0,  0,  0,       1, 6));
    vecs.push_back(mk("tie_recov",     2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 0,  0, 7,   1,  0,  0,       1, 6));
    vecs.push_back(mk("tie_redir",     2'b00, 2'b00, 0,   0,       0,   0,       0,   1, 0,  0, 7,   0,  1,  'h70,    1, 6));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush_valid", 64'(flush_valid), 0);
    chk("rst_flush_idx", 64'(flush_rob_idx), 0);
    chk("rst_recover_req", 64'(recover_req), 0);
    chk("rst_redirect_valid", 64'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stall", 64'(stall_issue), 0);
    chk("rst_count", 64'(mispredict_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      chk({vecs[k].name, ".flush_valid"}, 64'(flush_valid), 64'(vecs[k].e_flush));
      chk({vecs[k].name, ".recover_req"}, 64'(recover_req), 64'(vecs[k].e_rec));
      chk({vecs[k].name, ".redirect_valid"}, 64'(redirect_valid), 64'(vecs[k].e_redir));
      chk({vecs[k].name, ".stall_issue"}, 64'(stall_issue), 64'(vecs[k].e_stall));
      chk({vecs[k].name, ".count"}, 64'(mispredict_count), 64'(vecs[k].e_cnt));
      if (vecs[k].e_stall) chk({vecs[k].name, ".flush_idx"}, 64'(flush_rob_idx), 64'(vecs[k].e_idx));
      if (vecs[k].e_redir) chk({vecs[k].name, ".redirect_pc"}, redirect_pc, vecs[k].e_pc);
    end

    // Backpressure: hold REDIRECT while fetch is not ready.
    for (int c = 0; c < 5; c++) begin
      idle_inputs(0, 1'b0, 1'b0);
      chk("bp.redirect_valid", 64'(redirect_valid), 1);
      chk("bp.redirect_pc", redirect_pc, 64'h70);
      chk("bp.stall", 64'(stall_issue), 1);
    end
    idle_inputs(0, 1'b0, 1'b1);
    chk("bp_release.redirect_valid", 64'(redirect_valid), 0);
    chk("bp_release.stall", 64'(stall_issue), 0);
    chk("bp_release.count", 64'(mispredict_count), 6);

    // Reset asserted mid-REDIRECT clears everything asynchronously.
    win0(9'd9, 64'h900, 9'd0, 1'b1, 1'b0);
    idle_inputs(0, 1'b1, 1'b0);
    idle_inputs(0, 1'b1, 1'b0);
    chk("pre_rst.redirect_valid", 64'(redirect_valid), 1);
    chk("pre_rst.redirect_pc", redirect_pc, 64'h900);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.flush_valid", 64'(flush_valid), 0);
    chk("midrst.flush_idx", 64'(flush_rob_idx), 0);
    chk("midrst.recover_req", 64'(recover_req), 0);
    chk("midrst.redirect_valid", 64'(redirect_valid), 0);
    chk("midrst.redirect_pc", redirect_pc, 0);
    chk("midrst.stall", 64'(stall_issue), 0);
    chk("midrst.count", 64'(mispredict_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle_inputs(0, 1'b1, 1'b1);
      chk("post_rst.redirect_valid", 64'(redirect_valid), 0);
      chk("post_rst.flush_valid", 64'(flush_valid), 0);
      chk("post_rst.stall", 64'(stall_issue), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/superh16_branch_recovery_ctrl.md
# superh16_branch_recovery_ctrl

Sequences misprediction recovery for the SuperH16 execute cluster. It collects resolution reports from all branch execution units and selects the oldest mispredicted branch by ROB age. It then drives the recovery in order: ROB/pipeline flush, rename-state restore, and fetch redirect. It sits between the branch units and the ROB, rename and fetch front-end, and stalls issue while recovery is in progress.

## Interface
Parameters:
- NUM_BR_UNITS, 2, number of branch execution units reporting per cycle
- ROB_IDX_BITS, 9, ROB index width; the ROB is circular with 2^ROB_IDX_BITS entries
- VADDR_WIDTH, 64, virtual address width
- CNT_WIDTH, 32, width of the misprediction performance counter

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- br_resolved  in  NUM_BR_UNITS  per-unit resolution valid
- br_mispredicted  in  NUM_BR_UNITS  per-unit mispredict flag; qualified by br_resolved
- br_rob_idx  in  NUM_BR_UNITS x ROB_IDX_BITS  ROB index of the resolving branch
- br_target  in  NUM_BR_UNITS x VADDR_WIDTH  correct next PC
- rob_head_idx  in  ROB_IDX_BITS  oldest in-flight ROB entry, used as the age reference
- flush_valid  out  1  one-cycle pulse; squash everything younger than flush_rob_idx
- flush_rob_idx  out  ROB_IDX_BITS  ROB index of the mispredicted branch being recovered
- recover_req  out  1  rename-checkpoint restore request, level
- recover_done  in  1  rename restore complete
- redirect_valid  out  1  fetch redirect, level
- redirect_pc  out  VADDR_WIDTH  redirect target
- fetch_ready  in  1  fetch accepts the redirect
- stall_issue  out  1  high whenever the FSM is not IDLE
- mispredict_count  out  CNT_WIDTH  saturating count of accepted recoveries

## Operation
- A candidate is any unit i with br_resolved[i] && br_mispredicted[i].
- Age of a candidate is (br_rob_idx[i] - rob_head_idx) mod 2^ROB_IDX_BITS. A smaller age is older.
- The oldest candidate wins. If ages are equal, the lower unit index wins.
- The accepted winner's rob_idx and target are latched into cur_idx and cur_pc, and mispredict_count increments, saturating at all-ones.
- FSM states are IDLE, FLUSH, RECOVER and REDIRECT.
- IDLE: a winner exists -> latch it, go to FLUSH.
- FLUSH: flush_valid=1 for exactly this cycle. Next state is RECOVER.
- RECOVER: recover_req=1. recover_done high -> go to REDIRECT.
- REDIRECT: redirect_valid=1 and redirect_pc=cur_pc. fetch_ready high -> go to IDLE.
- Preemption, in any non-IDLE state:
  - If a winner arrives whose age is strictly less than the age of cur_idx (both measured from the current rob_head_idx), it is latched, the count increments, and the next state is FLUSH.
  - recover_req and redirect_valid deassert on that transition.
  - Winners that are the same age or younger are dropped; they are already squashed by the pending flush.
- A handshake completing in the same cycle as a preemption (recover_done or fetch_ready) is consumed but ignored. Preemption has priority.
- Correctly predicted resolutions (br_mispredicted=0) are ignored.
- ROB wrap-around is handled by the modular age arithmetic only. Raw indices are never compared directly.

## Timing
- Reset values: FSM=IDLE, flush_valid=0, flush_rob_idx=0, recover_req=0, redirect_valid=0, redirect_pc=0, stall_issue=0, mispredict_count=0.
- Inputs are sampled at rising edge N, and all outputs are registered.
- Minimum latencies after a winner is sampled at edge N:
  - flush_valid is high during cycle N+1.
  - recover_req rises at N+2.
  - With recover_done high in cycle N+2, redirect_valid rises at N+3.
  - With fetch_ready already high, the FSM returns to IDLE at N+4.
- flush_rob_idx is held stable from FLUSH through REDIRECT. redirect_pc is held stable for the whole of REDIRECT.
- stall_issue is registered and equal to (state != IDLE).
- Reset asserted mid-recovery forces all outputs to their reset values immediately. No partial redirect is issued.

## Test plan
- Single mispredict: unit0 idx=5, target=0x1000, head=0, recover_done tied high, fetch_ready tied high -> flush pulse with idx 5 at N+1, redirect 0x1000 at N+3, IDLE at N+4, count=1.
- Dual, with wrap: head=500, unit0 idx=10 (age 22), unit1 idx=505 (age 5) -> unit1 wins, flush_rob_idx=505, count=1.
- Preemption in RECOVER: cur_idx=40, head=0, idx=20 arrives -> second flush pulse with idx 20 the next cycle, redirect target equals the idx-20 target, count=2.
- Younger drop: in REDIRECT with cur_idx=20, idx=30 arrives -> no state change, redirect target unchanged, count unchanged.
- Backpressure: fetch_ready low for 5 cycles -> redirect_valid and redirect_pc stay stable and stall_issue stays high; IDLE follows the cycle after fetch_ready rises.
- Reset during REDIRECT -> all outputs 0 immediately; after release, no redirect is issued without new input.
